mem_port_arbiter: RTL and testbench

//  Sequences one shared single-port memory (memory2-style) among three requesters:
//  the instruction loader, MEM-stage load/store and IF-stage fetch.

---
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the three requester handshakes (loader, data, fetch), the stall
//          outputs and the shared single-port memory bus of mem_port_arbiter.
// Ports:   slave modport = arbiter side; master modport = requesters + memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Loader (write-only requester)
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_ack;
    // MEM-stage load/store
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    // IF-stage fetch (read-only requester)
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic [DW-1:0] f_rdata;
    // Pipeline hold controls
    logic          f_stall;
    logic          d_stall;
    // Shared memory port
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    // Status
    logic [1:0]    grant;
    logic          busy;

    modport slave (
        input  ld_req, ld_addr, ld_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  f_req, f_addr,
        input  mem_rdata,
        output ld_ack, d_ack, d_rdata, f_ack, f_rdata,
        output f_stall, d_stall,
        output mem_re, mem_we, mem_addr, mem_wdata,
        output grant, busy
    );

    modport master (
        output ld_req, ld_addr, ld_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output f_req, f_addr,
        output mem_rdata,
        input  ld_ack, d_ack, d_rdata, f_ack, f_rdata,
        input  f_stall, d_stall,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        input  grant, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: sequences one single-port memory among loader, MEM-stage data and IF fetch
//          (fixed priority loader > data > fetch) with req/ack handshakes.
// Latency: read ack MEM_LAT+1 cycles after req is seen in IDLE, write ack after 2; one IDLE cycle between transactions.
// Backpressure: losers simply keep req high; f_stall/d_stall = req & ~ack hold the pipeline.
// Ports: clk, Reset (async, active-high), bus (mem_port_arbiter_if.slave: requester
//        req/addr/wdata/ack/rdata, f_stall/d_stall, mem_re/we/addr/wdata/rdata, grant, busy).
// Option: define ARB_FAIR_EN to alternate data/fetch when both contend with no loader request.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1      // 1..15 cycles from mem_re to valid mem_rdata
) (
    input  logic                clk,
    input  logic                Reset,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] GNT_NONE   = 2'b00;
    localparam logic [1:0] GNT_FETCH  = 2'b01;
    localparam logic [1:0] GNT_DATA   = 2'b10;
    localparam logic [1:0] GNT_LOADER = 2'b11;

    // Counter preload: ISSUE already accounts for one latency cycle.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);

    state_t        state;
    logic [1:0]    grantReg;
    logic          curWe;
    logic          memRe;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic [3:0]    waitCnt;
    logic          ldAck;
    logic          dAck;
    logic          fAck;
    logic [1:0]    winner;

`ifdef ARB_FAIR_EN
    logic lastDp;       // 1 = data won the most recent data-vs-fetch contest
    logic contested;

    always_comb begin
        contested = bus.d_req & bus.f_req & ~bus.ld_req;
        winner    = GNT_NONE;
        if (bus.ld_req)
            winner = GNT_LOADER;
        else if (contested)
            winner = lastDp ? GNT_FETCH : GNT_DATA;
        else if (bus.d_req)
            winner = GNT_DATA;
        else if (bus.f_req)
            winner = GNT_FETCH;
    end

    // Only genuine data-vs-fetch contests move the fairness pointer.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            lastDp <= 1'b0;
        else if (state == IDLE && contested)
            lastDp <= (winner == GNT_DATA);
    end
`else
    always_comb begin
        winner = GNT_NONE;
        if (bus.ld_req)
            winner = GNT_LOADER;
        else if (bus.d_req)
            winner = GNT_DATA;
        else if (bus.f_req)
            winner = GNT_FETCH;
    end
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            grantReg <= GNT_NONE;
            curWe    <= 1'b0;
            memRe    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            waitCnt  <= 4'd0;
            ldAck    <= 1'b0;
            dAck     <= 1'b0;
            fAck     <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses unless re-armed below.
            memRe <= 1'b0;
            memWe <= 1'b0;
            ldAck <= 1'b0;
            dAck  <= 1'b0;
            fAck  <= 1'b0;
            case (state)
                IDLE: begin
                    if (winner != GNT_NONE) begin
                        grantReg <= winner;
                        state    <= ISSUE;
                        case (winner)
                            GNT_LOADER: begin
                                memAddr  <= bus.ld_addr;
                                memWdata <= bus.ld_wdata;
                                curWe    <= 1'b1;
                                memWe    <= 1'b1;
                            end
                            GNT_DATA: begin
                                memAddr  <= bus.d_addr;
                                memWdata <= bus.d_wdata;
                                curWe    <= bus.d_we;
                                memWe    <= bus.d_we;
                                memRe    <= ~bus.d_we;
                            end
                            default: begin
                                memAddr <= bus.f_addr;
                                curWe   <= 1'b0;
                                memRe   <= 1'b1;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    if (curWe || (MEM_LAT == 1)) begin
                        state <= RESP;
                        ldAck <= (grantReg == GNT_LOADER);
                        dAck  <= (grantReg == GNT_DATA);
                        fAck  <= (grantReg == GNT_FETCH);
                    end else begin
                        waitCnt <= WAIT_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (waitCnt <= 4'd1) begin
                        waitCnt <= 4'd0;
                        state   <= RESP;
                        ldAck   <= (grantReg == GNT_LOADER);
                        dAck    <= (grantReg == GNT_DATA);
                        fAck    <= (grantReg == GNT_FETCH);
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                default: begin   // RESP
                    state    <= IDLE;
                    grantReg <= GNT_NONE;
                end
            endcase
        end
    end

    assign bus.ld_ack    = ldAck;
    assign bus.d_ack     = dAck;
    assign bus.f_ack     = fAck;
    // Read data is only meaningful while the matching ack is high.
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.f_rdata   = bus.mem_rdata;
    assign bus.f_stall   = bus.f_req & ~fAck;
    assign bus.d_stall   = bus.d_req & ~dAck;
    assign bus.mem_re    = memRe;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.grant     = grantReg;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1, 3, 4) sharing clk/Reset.
module tb_mem_port_arbiter;
    logic clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) ifc1 ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) ifc3 ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) ifc4 ();

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (.clk(clk), .Reset(Reset), .bus(ifc1.slave));
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (.clk(clk), .Reset(Reset), .bus(ifc3.slave));
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) dut4 (.clk(clk), .Reset(Reset), .bus(ifc4.slave));

    typedef struct {
        logic        ld, d, we, f;
        logic [31:0] ldA, dA, fA, ldWd, dWd, rdata;
        logic [1:0]  eGrant;
        logic [31:0] eAddr, eWdata;
        logic        eRe, eWe;
        logic [2:0]  eAck;      // {ld, d, f}
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [1:0]  gseq[4];
        logic [1:0]  expSeq[4];
        logic [1:0]  prevG;
        int          nG;
        int          ackCyc;
        int          reCnt;
        int          fAcks;
        logic        ackSeen;
        logic [2:0]  done;

        // field order: ld d we f | ldA dA fA | ldWd dWd rdata | eGrant eAddr eWdata eRe eWe eAck
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h10, 32'h0, 32'h0, 32'h8C220004,
                    2'b01, 32'h10, 32'h0, 1'b1, 1'b0, 3'b001};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0,
                    2'b10, 32'h40, 32'hDEADBEEF, 1'b0, 1'b1, 3'b010};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h84, 32'h0, 32'h0, 32'h0, 32'h12345678,
                    2'b10, 32'h84, 32'h0, 1'b1, 1'b0, 3'b010};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h20080005, 32'h0, 32'h0,
                    2'b11, 32'h0, 32'h20080005, 1'b0, 1'b1, 3'b100};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 32'h300, 32'h400, 32'hCAFEF00D, 32'h11111111, 32'h0,
                    2'b11, 32'h200, 32'hCAFEF00D, 1'b0, 1'b1, 3'b100};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h500, 32'h600, 32'h0, 32'h0, 32'hA5A5A5A5,
                    2'b10, 32'h500, 32'h0, 1'b1, 1'b0, 3'b010};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h700, 32'h0, 32'h704, 32'h0000FFFF, 32'h0, 32'h0,
                    2'b11, 32'h700, 32'h0000FFFF, 1'b0, 1'b1, 3'b100};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFC, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0,
                    2'b10, 32'hFFFFFFFC, 32'hFFFFFFFF, 1'b0, 1'b1, 3'b010};

        ifc1.ld_req = 1'b0; ifc1.ld_addr = '0; ifc1.ld_wdata = '0; ifc1.d_req = 1'b0; ifc1.d_we = 1'b0;
        ifc1.d_addr = '0; ifc1.d_wdata = '0; ifc1.f_req = 1'b0; ifc1.f_addr = '0; ifc1.mem_rdata = '0;
        ifc3.ld_req = 1'b0; ifc3.ld_addr = '0; ifc3.ld_wdata = '0; ifc3.d_req = 1'b0; ifc3.d_we = 1'b0;
        ifc3.d_addr = '0; ifc3.d_wdata = '0; ifc3.f_req = 1'b0; ifc3.f_addr = '0; ifc3.mem_rdata = '0;
        ifc4.ld_req = 1'b0; ifc4.ld_addr = '0; ifc4.ld_wdata = '0; ifc4.d_req = 1'b0; ifc4.d_we = 1'b0;
        ifc4.d_addr = '0; ifc4.d_wdata = '0; ifc4.f_req = 1'b0; ifc4.f_addr = '0; ifc4.mem_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_busy",   32'(ifc1.busy), 32'h0);
        chk("rst_grant",  32'(ifc1.grant), 32'h0);
        chk("rst_mem_re", 32'(ifc1.mem_re), 32'h0);
        chk("rst_mem_we", 32'(ifc1.mem_we), 32'h0);
        chk("rst_addr",   ifc1.mem_addr, 32'h0);
        chk("rst_wdata",  ifc1.mem_wdata, 32'h0);
        chk("rst_acks",   32'({ifc1.ld_ack, ifc1.d_ack, ifc1.f_ack}), 32'h0);
        chk("rst_busy4",  32'(ifc4.busy), 32'h0);
        Reset = 1'b0;

        // Single-transaction vectors on the MEM_LAT=1 instance
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            ifc1.ld_req = v.ld;  ifc1.ld_addr = v.ldA; ifc1.ld_wdata = v.ldWd;
            ifc1.d_req  = v.d;   ifc1.d_we    = v.we;  ifc1.d_addr   = v.dA; ifc1.d_wdata = v.dWd;
            ifc1.f_req  = v.f;   ifc1.f_addr  = v.fA;  ifc1.mem_rdata = v.rdata;
            tick();   // ISSUE
            chk($sformatf("v%0d_grant", i),  32'(ifc1.grant), 32'(v.eGrant));
            chk($sformatf("v%0d_addr", i),   ifc1.mem_addr, v.eAddr);
            chk($sformatf("v%0d_re", i),     32'(ifc1.mem_re), 32'(v.eRe));
            chk($sformatf("v%0d_we", i),     32'(ifc1.mem_we), 32'(v.eWe));
            chk($sformatf("v%0d_busy", i),   32'(ifc1.busy), 32'h1);
            chk($sformatf("v%0d_stall_issue", i), 32'({ifc1.f_stall, ifc1.d_stall}), 32'({v.f, v.d}));
            if (v.eWe)
                chk($sformatf("v%0d_wdata", i), ifc1.mem_wdata, v.eWdata);
            tick();   // RESP
            chk($sformatf("v%0d_acks", i), 32'({ifc1.ld_ack, ifc1.d_ack, ifc1.f_ack}), 32'(v.eAck));
            chk($sformatf("v%0d_strobes_off", i), 32'({ifc1.mem_re, ifc1.mem_we}), 32'h0);
            chk($sformatf("v%0d_stall_resp", i), 32'({ifc1.f_stall, ifc1.d_stall}),
                32'({v.f & ~v.eAck[0], v.d & ~v.eAck[1]}));
            if (v.eAck[1] && !v.we)
                chk($sformatf("v%0d_d_rdata", i), ifc1.d_rdata, v.rdata);
            if (v.eAck[0])
                chk($sformatf("v%0d_f_rdata", i), ifc1.f_rdata, v.rdata);
            ifc1.ld_req = 1'b0; ifc1.d_req = 1'b0; ifc1.f_req = 1'b0;
            tick();   // IDLE
            chk($sformatf("v%0d_idle_busy", i),  32'(ifc1.busy), 32'h0);
            chk($sformatf("v%0d_idle_grant", i), 32'(ifc1.grant), 32'h0);
        end

        // Reset in the middle of WAIT (MEM_LAT=3)
        ifc3.f_addr = 32'h20; ifc3.f_req = 1'b1;
        tick();
        chk("rstw_issue_re", 32'(ifc3.mem_re), 32'h1);
        tick();
        chk("rstw_wait_busy", 32'(ifc3.busy), 32'h1);
        chk("rstw_wait_re",   32'(ifc3.mem_re), 32'h0);
        #1 Reset = 1'b1;
        ifc3.f_req = 1'b0;
        #1;
        chk("rstw_busy",  32'(ifc3.busy), 32'h0);
        chk("rstw_grant", 32'(ifc3.grant), 32'h0);
        chk("rstw_re",    32'(ifc3.mem_re), 32'h0);
        @(negedge clk) Reset = 1'b0;
        ackSeen = 1'b0;
        repeat (8) begin
            tick();
            if (ifc3.f_ack) ackSeen = 1'b1;
        end
        chk("rstw_no_ack", 32'(ackSeen), 32'h0);
        chk("rstw_idle_busy", 32'(ifc3.busy), 32'h0);

        // MEM_LAT=3 read latency
        ifc3.f_addr = 32'h24; ifc3.mem_rdata = 32'h13579BDF; ifc3.f_req = 1'b1;
        ackCyc = -1;
        for (int c = 1; c <= 20 && ackCyc < 0; c++) begin
            tick();
            if (ifc3.f_ack) begin
                ackCyc = c;
                chk("lat3_f_rdata", ifc3.f_rdata, 32'h13579BDF);
                ifc3.f_req = 1'b0;
            end
        end
        chk("lat3_ack_cycle", 32'(ackCyc), 32'd4);

        // MEM_LAT=4 read latency
        ifc4.d_we = 1'b0; ifc4.d_addr = 32'h80; ifc4.mem_rdata = 32'h0BADF00D; ifc4.d_req = 1'b1;
        ackCyc = -1; reCnt = 0;
        for (int c = 1; c <= 20 && ackCyc < 0; c++) begin
            tick();
            if (ifc4.mem_re) reCnt++;
            if (c == 1) begin
                chk("lat4_issue_re",   32'(ifc4.mem_re), 32'h1);
                chk("lat4_issue_addr", ifc4.mem_addr, 32'h80);
                chk("lat4_stall",      32'(ifc4.d_stall), 32'h1);
            end
            if (ifc4.d_ack) begin
                ackCyc = c;
                chk("lat4_d_rdata", ifc4.d_rdata, 32'h0BADF00D);
                ifc4.d_req = 1'b0;
            end
        end
        chk("lat4_ack_cycle", 32'(ackCyc), 32'd5);
        chk("lat4_re_cycles", 32'(reCnt), 32'd1);

        // All three requesters at once: loader, data, fetch in order
        tick();
        ifc1.ld_addr = 32'h1000; ifc1.ld_wdata = 32'h1;
        ifc1.d_we = 1'b0; ifc1.d_addr = 32'h2000;
        ifc1.f_addr = 32'h3000;
        ifc1.ld_req = 1'b1; ifc1.d_req = 1'b1; ifc1.f_req = 1'b1;
        for (int k = 0; k < 4; k++) gseq[k] = 2'b00;
        nG = 0; prevG = 2'b00; done = 3'b000;
        for (int c = 0; c < 40 && done != 3'b111; c++) begin
            tick();
            if (ifc1.grant != 2'b00 && prevG == 2'b00 && nG < 4) begin
                gseq[nG] = ifc1.grant;
                nG++;
            end
            prevG = ifc1.grant;
            if (ifc1.ld_ack) begin ifc1.ld_req = 1'b0; done[2] = 1'b1; end
            if (ifc1.d_ack)  begin ifc1.d_req  = 1'b0; done[1] = 1'b1; end
            if (ifc1.f_ack)  begin ifc1.f_req  = 1'b0; done[0] = 1'b1; end
        end
        chk("prio_count", 32'(nG), 32'd3);
        chk("prio_g0", 32'(gseq[0]), 32'h3);
        chk("prio_g1", 32'(gseq[1]), 32'h2);
        chk("prio_g2", 32'(gseq[2]), 32'h1);
        ifc1.ld_req = 1'b0; ifc1.d_req = 1'b0; ifc1.f_req = 1'b0;
        tick(); tick();

        // Data and fetch held high continuously (fairness pointer cleared by reset)
        Reset = 1'b1;
        @(negedge clk) Reset = 1'b0;
        tick();
`ifdef ARB_FAIR_EN
        expSeq[0] = 2'b10; expSeq[1] = 2'b01; expSeq[2] = 2'b10; expSeq[3] = 2'b01;
`else
        expSeq[0] = 2'b10; expSeq[1] = 2'b10; expSeq[2] = 2'b10; expSeq[3] = 2'b10;
`endif
        ifc1.d_we = 1'b1; ifc1.d_addr = 32'h44; ifc1.d_wdata = 32'h55AA55AA; ifc1.f_addr = 32'h48;
        ifc1.d_req = 1'b1; ifc1.f_req = 1'b1;
        for (int k = 0; k < 4; k++) gseq[k] = 2'b00;
        nG = 0; prevG = 2'b00; fAcks = 0;
        for (int c = 0; c < 40 && nG < 4; c++) begin
            tick();
            if (ifc1.f_ack) fAcks++;
            if (ifc1.grant != 2'b00 && prevG == 2'b00) begin
                gseq[nG] = ifc1.grant;
                nG++;
            end
            prevG = ifc1.grant;
        end
        chk("fair_count", 32'(nG), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("fair_g%0d", k), 32'(gseq[k]), 32'(expSeq[k]));
`ifdef ARB_FAIR_EN
        chk("fair_f_acks", 32'(fAcks), 32'd1);
`else
        chk("fair_f_acks", 32'(fAcks), 32'd0);
`endif
        ifc1.d_req = 1'b0; ifc1.f_req = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
